// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: merges the pipeline WB write with results from the
// long-latency unit, buffering up to two of those results and forcing a drain when one starves.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_reg_W,
    input  logic [4:0]  rd_W,
    input  logic [31:0] wb_data_W,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_pipe,
    output logic [1:0]  lu_pending
);

    logic [4:0]  q_rd   [2];
    logic [31:0] q_data [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, starve;

    logic        has_head, accept, head_grant, pipe_grant, bypass, push;
    logic        sel_valid;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // Every output is gated by rst_n so reset quiets the port in the same cycle.
    assign has_head   = (count != 2'd0);
    assign lu_ready   = rst_n && (count != 2'd2);
    assign accept     = lu_valid && lu_ready;
    assign stall_pipe = rst_n && (starve == 2'd3) && has_head;
    assign head_grant = rst_n && (stall_pipe || (!we_reg_W && has_head));
    assign pipe_grant = rst_n && !stall_pipe && we_reg_W;
    assign bypass     = rst_n && !stall_pipe && !we_reg_W && !has_head && accept;
    assign push       = accept && !bypass;
    assign lu_pending = rst_n ? count : 2'd0;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = 32'd0;
        if (head_grant) begin
            sel_valid = 1'b1;
            sel_rd    = q_rd[rd_ptr];
            sel_data  = q_data[rd_ptr];
        end else if (pipe_grant) begin
            sel_valid = 1'b1;
            sel_rd    = rd_W;
            sel_data  = wb_data_W;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_rd    = lu_rd;
            sel_data  = lu_data;
        end
    end

    // x0 writes are still consumed; only the enable is dropped.
    assign rf_we    = sel_valid && (sel_rd != 5'd0);
    assign rf_waddr = sel_rd;
    assign rf_wdata = sel_data;

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lu_rd;
            q_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            starve <= 2'd0;
        end else begin
            if (push)       wr_ptr <= ~wr_ptr;
            if (head_grant) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, head_grant};
            if (!has_head || head_grant)
                starve <= 2'd0;
            else if (starve != 2'd3)
                starve <= starve + 2'd1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: register-file writes are checked against a scoreboard
// queue in issue order, and flow-control outputs are checked inline by each scenario.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_reg_W;
    logic [4:0]  rd_W;
    logic [31:0] wb_data_W;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready, rf_we, stall_pipe;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  lu_pending;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [36:0] exp_q[$];

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .we_reg_W(we_reg_W), .rd_W(rd_W), .wb_data_W(wb_data_W),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_pipe(stall_pipe), .lu_pending(lu_pending)
    );

    always #5 clk = ~clk;

    // Scoreboard: every enabled write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got write x%0d=%h, expected no write", rf_waddr, rf_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h",
                             rf_waddr, rf_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we_reg_W = 1'b0; rd_W = 5'd0; wb_data_W = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we_reg_W = 1'b1; rd_W = 5'd3; wb_data_W = 32'hDEAD;
        lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (rf_we !== 1'b0)       begin n_fail++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
        n_chk++; if (lu_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_lu_ready: got %b expected 0", lu_ready); end
        n_chk++; if (stall_pipe !== 1'b0)  begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_pipe); end
        n_chk++; if (rf_waddr !== 5'd0)    begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
        n_chk++; if (rf_wdata !== 32'd0)   begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
        n_chk++; if (lu_pending !== 2'd0)  begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", lu_pending); end
        tick();
        rst_n = 1'b1;
        idle_in();
        tick();
    endtask

    task automatic test_bypass();
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'h1234;
        exp_q.push_back({5'd5, 32'h1234});
        @(negedge clk);
        n_chk++; if (rf_we !== 1'b1)      begin n_fail++; $display("FAIL bypass_we: got %b expected 1", rf_we); end
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL bypass_pending: got %0d expected 0", lu_pending); end
        tick();
        idle_in();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL bypass_pending_after: got %0d expected 0", lu_pending); end
        tick();
    endtask

    task automatic test_conflict();
        we_reg_W = 1'b1; rd_W = 5'd3; wb_data_W = 32'hA;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hB;
        exp_q.push_back({5'd3, 32'hA});
        @(negedge clk);
        n_chk++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL conflict_ready: got %b expected 1", lu_ready); end
        tick();
        idle_in();
        exp_q.push_back({5'd7, 32'hB});
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd1) begin n_fail++; $display("FAIL conflict_pending1: got %0d expected 1", lu_pending); end
        tick();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL conflict_pending0: got %0d expected 0", lu_pending); end
        tick();
    endtask

    task automatic test_full();
        we_reg_W = 1'b1; rd_W = 5'd1;
        wb_data_W = 32'h100; lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA0;
        exp_q.push_back({5'd1, 32'h100});
        @(negedge clk);
        n_chk++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready0: got %b expected 1", lu_ready); end
        tick();
        wb_data_W = 32'h101; lu_rd = 5'd11; lu_data = 32'hA1;
        exp_q.push_back({5'd1, 32'h101});
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd1) begin n_fail++; $display("FAIL full_pending1: got %0d expected 1", lu_pending); end
        tick();
        // third result is held on the bus until a slot frees up
        wb_data_W = 32'h102; lu_rd = 5'd12; lu_data = 32'hA2;
        exp_q.push_back({5'd1, 32'h102});
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd2) begin n_fail++; $display("FAIL full_pending2: got %0d expected 2", lu_pending); end
        n_chk++; if (lu_ready !== 1'b0)   begin n_fail++; $display("FAIL full_ready_full: got %b expected 0", lu_ready); end
        tick();
        wb_data_W = 32'h103;
        exp_q.push_back({5'd1, 32'h103});
        @(negedge clk);
        n_chk++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL full_nostall: got %b expected 0", stall_pipe); end
        n_chk++; if (lu_ready !== 1'b0)   begin n_fail++; $display("FAIL full_ready_held: got %b expected 0", lu_ready); end
        tick();
        wb_data_W = 32'h104;
        exp_q.push_back({5'd10, 32'hA0});
        @(negedge clk);
        n_chk++; if (stall_pipe !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b expected 1", stall_pipe); end
        tick();
        exp_q.push_back({5'd1, 32'h104});
        @(negedge clk);
        n_chk++; if (lu_ready !== 1'b1)   begin n_fail++; $display("FAIL full_ready_after_pop: got %b expected 1", lu_ready); end
        n_chk++; if (lu_pending !== 2'd1) begin n_fail++; $display("FAIL full_pending_after_pop: got %0d expected 1", lu_pending); end
        tick();
        idle_in();
        exp_q.push_back({5'd11, 32'hA1});
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd2) begin n_fail++; $display("FAIL full_pending_refill: got %0d expected 2", lu_pending); end
        tick();
        exp_q.push_back({5'd12, 32'hA2});
        tick();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", lu_pending); end
        tick();
    endtask

    task automatic test_starve();
        we_reg_W = 1'b1; rd_W = 5'd2; wb_data_W = 32'd200;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        exp_q.push_back({5'd2, 32'd200});
        tick();
        lu_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wb_data_W = 32'd200 + i;
            exp_q.push_back({5'd2, wb_data_W});
            @(negedge clk);
            n_chk++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL starve_early_c%0d: got %b expected 0", i, stall_pipe); end
            tick();
        end
        wb_data_W = 32'd204;
        exp_q.push_back({5'd9, 32'h99});
        @(negedge clk);
        n_chk++; if (stall_pipe !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b expected 1", stall_pipe); end
        tick();
        exp_q.push_back({5'd2, 32'd204});
        @(negedge clk);
        n_chk++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b expected 0", stall_pipe); end
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL starve_pending: got %0d expected 0", lu_pending); end
        tick();
        idle_in();
        tick();
    endtask

    task automatic test_x0();
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_bypass_we: got %b expected 0", rf_we); end
        tick();
        idle_in();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL x0_bypass_pending: got %0d expected 0", lu_pending); end
        tick();
        we_reg_W = 1'b1; rd_W = 5'd3; wb_data_W = 32'd5;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hFFFF_FFFF;
        exp_q.push_back({5'd3, 32'd5});
        tick();
        idle_in();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd1) begin n_fail++; $display("FAIL x0_buffered: got %0d expected 1", lu_pending); end
        n_chk++; if (rf_we !== 1'b0)      begin n_fail++; $display("FAIL x0_pop_we: got %b expected 0", rf_we); end
        tick();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL x0_consumed: got %0d expected 0", lu_pending); end
        tick();
    endtask

    task automatic test_reset_mid();
        we_reg_W = 1'b1; rd_W = 5'd1; wb_data_W = 32'd300;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'hC0;
        exp_q.push_back({5'd1, 32'd300});
        tick();
        wb_data_W = 32'd301; lu_rd = 5'd21; lu_data = 32'hC1;
        exp_q.push_back({5'd1, 32'd301});
        tick();
        wb_data_W = 32'd302; lu_valid = 1'b0;
        exp_q.push_back({5'd1, 32'd302});
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd2) begin n_fail++; $display("FAIL rmid_pending2: got %0d expected 2", lu_pending); end
        tick();
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rmid_reset_we: got %b expected 0", rf_we); end
        tick();
        rst_n = 1'b1;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'd44;
        exp_q.push_back({5'd4, 32'd44});
        @(negedge clk);
        n_chk++; if (lu_ready !== 1'b1)   begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", lu_ready); end
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL rmid_pending0: got %0d expected 0", lu_pending); end
        tick();
        idle_in();
        repeat (3) tick();
        @(negedge clk);
        n_chk++; if (lu_pending !== 2'd0) begin n_fail++; $display("FAIL rmid_no_old: got %0d expected 0", lu_pending); end
        tick();
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        test_reset();
        test_bypass();
        test_conflict();
        test_full();
        test_starve();
        test_x0();
        test_reset_mid();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on posedge clk.
REQ-003 SHALL have port we_reg_W, input, 1, pipeline WB-stage register write enable.
REQ-004 SHALL have port rd_W, input, 5, pipeline WB destination register.
REQ-005 SHALL have port wb_data_W, input, 32, pipeline WB write data (already muxed per wb_ctrl).
REQ-006 SHALL have port lu_valid, input, 1, long-latency unit (mul/div) result valid.
REQ-007 SHALL have port lu_rd, input, 5, long-latency unit destination register.
REQ-008 SHALL have port lu_data, input, 32, long-latency unit result.
REQ-009 SHALL have port lu_ready, output, 1, arbiter can accept a long-latency result.
REQ-010 SHALL have port rf_we, output, 1, register-file write enable.
REQ-011 SHALL have port rf_waddr, output, 5, register-file write address.
REQ-012 SHALL have port rf_wdata, output, 32, register-file write data.
REQ-013 SHALL have port stall_pipe, output, 1, freeze request to all pipeline registers up to and including ME/WB.
REQ-014 SHALL have port lu_pending, output, 2, number of buffered long-latency results (0..2).

Function
REQ-015 SHALL hold long-latency results in a 2-entry FIFO of {rd[4:0], data[31:0]}, with registered count.
REQ-016 SHALL drive lu_ready = 1 iff count < 2, from registered count only; no push-through-pop when full.
REQ-017 SHALL accept a result on a cycle with lu_valid && lu_ready; no acceptance otherwise.
REQ-018 SHALL select the single write source combinationally per cycle in priority order: (a) FIFO head if stall_pipe; (b) pipeline WB if we_reg_W; (c) FIFO head if count>0; (d) accepted lu input directly (bypass) if count==0; (e) none.
REQ-019 SHALL pop FIFO head when granted; SHALL not push an accepted result that was bypassed.
REQ-020 SHALL support push and pop in the same cycle; count unchanged; new entry queued behind remaining entries.
REQ-021 SHALL, with count==0, a pipeline write, and an accepted lu result in the same cycle, grant the pipeline and push the lu result.
REQ-022 SHALL suppress rf_we when selected address is 0; the entry is still consumed (popped/bypassed/pipeline retired).
REQ-023 SHALL drive rf_waddr/rf_wdata from the selected source; both 0 when no source selected.
REQ-024 SHALL maintain a 2-bit starve counter: +1 (saturating at 3) on each cycle count>0 and FIFO head not granted; cleared when head granted or count==0.
REQ-025 SHALL assert stall_pipe = (starve==3) && (count>0), combinational from registered state; lasts exactly the cycle the head is forced.
REQ-026 SHALL ignore we_reg_W during a stall_pipe cycle; the frozen pipeline presents the same WB write next cycle.
REQ-027 SHALL drive lu_pending = registered count.
REQ-028 SHALL write at most one register per cycle; FIFO order = acceptance order.

Reset
REQ-029 SHALL, while rst_n=0 at posedge clk, clear FIFO count, read/write pointers and starve counter to 0.
REQ-030 SHALL force rf_we=0, lu_ready=0, stall_pipe=0, rf_waddr=0, rf_wdata=0, lu_pending=0 while rst_n=0, independent of other inputs.
REQ-031 SHALL discard buffered results on reset mid-operation; no write of discarded entries after reset release.
REQ-032 SHALL accept lu results from the first cycle after rst_n returns high.

Verification
REQ-033 SHALL cover bypass: idle, lu_valid=1, lu_rd=5, lu_data=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, lu_pending stays 0.
REQ-034 SHALL cover conflict: we_reg_W=1 rd_W=3 data=0xA and lu_valid rd=7 data=0xB same cycle -> write x3=0xA; next idle cycle write x7=0xB; lu_pending 1 then 0.
REQ-035 SHALL cover full: we_reg_W=1 continuously, two lu results accepted -> lu_pending=2, lu_ready=0; third lu_valid held until a pop.
REQ-036 SHALL cover starvation: we_reg_W=1 every cycle, one buffered entry -> stall_pipe=1 on 4th cycle after push, head written that cycle, pipeline write occurs following cycle, starve cleared.
REQ-037 SHALL cover x0: lu result rd=0 data=0xFFFF_FFFF -> rf_we=0, entry consumed, lu_pending unchanged/decremented accordingly.
REQ-038 SHALL cover reset mid-operation: lu_pending=2, rst_n=0 one cycle -> lu_pending=0, no write of old entries, lu_ready=1 first cycle after release.
